// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: control bundle width and bit positions
// of the WB/M/EX control fields and the extra opcode flags.
package mips_pkg;

    localparam int CTRL_W = 9;
    localparam int EXT_W  = 4;

    // Control bundle bit positions: WB = [8:7], M = [6:4], EX = [3:0]
    localparam int WB_MEMTOREG = 8;
    localparam int WB_REGWRITE = 7;
    localparam int M_BRANCH    = 6;
    localparam int M_MEMREAD   = 5;
    localparam int M_MEMWRITE  = 4;
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUSRC   = 2;
    localparam int EX_RTYPE    = 1;
    localparam int EX_BEQ      = 0;

    // Extra opcode flags
    localparam int EXT_BNE  = 3;
    localparam int EXT_ANDI = 2;
    localparam int EXT_ORI  = 1;
    localparam int EXT_ADDI = 0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus. master = decode side driving ID fields, flush and hold
// and observing EX outputs; slave = the id_ex_stage register itself.
interface id_ex_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    import mips_pkg::*;

    logic [CTRL_W-1:0] ctrl_in;
    logic [EXT_W-1:0]  ext_in;
    logic              j_in;
    logic [DATA_W-1:0] id_pc4;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic              flush;
    logic              hold;

    logic [CTRL_W-1:0] ex_ctrl;
    logic [EXT_W-1:0]  ex_ext;
    logic [DATA_W-1:0] ex_pc4;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic [REG_W-1:0]  ex_rs;
    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  ex_rd;
    logic              pc_write;
    logic              ifid_write;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output ctrl_in, ext_in, j_in, id_pc4, id_rs_data, id_rt_data,
        output id_imm, id_rs, id_rt, id_rd, flush, hold,
        input  ex_ctrl, ex_ext, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
        input  ex_rs, ex_rt, ex_rd, pc_write, ifid_write, stall_count
    );

    modport slave (
        input  ctrl_in, ext_in, j_in, id_pc4, id_rs_data, id_rt_data,
        input  id_imm, id_rs, id_rt, id_rd, flush, hold,
        output ex_ctrl, ex_ext, ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
        output ex_rs, ex_rt, ex_rd, pc_write, ifid_write, stall_count
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector (combinational).
// Ports: i_ex_memread/i_ex_rt from EX, i_id_rs/i_id_rt/i_uses_* from ID,
// o_load_use high when the ID instruction needs the load's destination.
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_ex_memread,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_uses_rs,
    input  logic             i_uses_rt,
    output logic             o_load_use
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = i_uses_rs && (i_ex_rt == i_id_rs);
    assign w_rt_match = i_uses_rt && (i_ex_rt == i_id_rt);

    // r0 is hardwired zero, so a load into it never creates a dependency
    assign o_load_use = i_ex_memread && (i_ex_rt != '0)
                      && (w_rs_match || w_rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Ports: clk, rst (async active-high), bus (id_ex_stage_if.slave).
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [EXT_W-1:0]  r_ext;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [CNT_W-1:0]  r_cnt;

    logic w_uses_rs;
    logic w_uses_rt;
    logic w_load_use;
    logic w_hazard;
    logic w_bubble;

    // A jump does not read rs; rt is read by R-type, stores and branches
    assign w_uses_rs = ~bus.j_in;
    assign w_uses_rt = bus.ctrl_in[EX_REGDST]
                     | bus.ctrl_in[M_MEMWRITE]
                     | bus.ctrl_in[M_BRANCH]
                     | bus.ext_in[EXT_BNE];

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .i_ex_memread (r_ctrl[M_MEMREAD]),
        .i_ex_rt      (r_rt),
        .i_id_rs      (bus.id_rs),
        .i_id_rt      (bus.id_rt),
        .i_uses_rs    (w_uses_rs),
        .i_uses_rt    (w_uses_rt),
        .o_load_use   (w_load_use)
    );

    // A squashed instruction cannot stall the pipe
    assign w_hazard = w_load_use & ~bus.flush;
    assign w_bubble = bus.flush | w_hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_ext     <= '0;
            r_pc4     <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
        end else if (!bus.hold) begin
            r_ctrl    <= w_bubble ? '0 : bus.ctrl_in;
            r_ext     <= w_bubble ? '0 : bus.ext_in;
            r_pc4     <= bus.id_pc4;
            r_rs_data <= bus.id_rs_data;
            r_rt_data <= bus.id_rt_data;
            r_imm     <= bus.id_imm;
            r_rs      <= bus.id_rs;
            r_rt      <= bus.id_rt;
            r_rd      <= bus.id_rd;
            if (w_hazard && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.ex_ctrl     = r_ctrl;
    assign bus.ex_ext      = r_ext;
    assign bus.ex_pc4      = r_pc4;
    assign bus.ex_rs_data  = r_rs_data;
    assign bus.ex_rt_data  = r_rt_data;
    assign bus.ex_imm      = r_imm;
    assign bus.ex_rs       = r_rs;
    assign bus.ex_rt       = r_rt;
    assign bus.ex_rd       = r_rd;
    assign bus.stall_count = r_cnt;

    // Front end stays enabled throughout reset
    assign bus.pc_write    = rst | ~(bus.hold | w_hazard);
    assign bus.ifid_write  = rst | ~(bus.hold | w_hazard);

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios then random traffic,
// checked against a behavioural model; a 2-bit-counter copy shows saturation.
module tb_id_ex_stage;

    localparam logic [8:0] LW   = 9'b11_010_0100;
    localparam logic [8:0] RTYP = 9'b01_000_1010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bi ();
    id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(2))  bs ();

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bs)
    );

    int total = 0;
    int bad   = 0;

    // stimulus
    logic [8:0]  s_ctrl;
    logic [3:0]  s_ext;
    logic        s_j, s_flush, s_hold;
    logic [31:0] s_pc4, s_rsd, s_rtd, s_imm;
    logic [4:0]  s_rs, s_rt, s_rd;

    // model of the instruction sitting in EX
    logic [8:0]  m_ctrl;
    logic [3:0]  m_ext;
    logic [31:0] m_pc4, m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_rd;
    int          m_cnt, m_cnts;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bi.ctrl_in = s_ctrl; bs.ctrl_in = s_ctrl;
        bi.ext_in = s_ext;   bs.ext_in = s_ext;
        bi.j_in = s_j;       bs.j_in = s_j;
        bi.id_pc4 = s_pc4;   bs.id_pc4 = s_pc4;
        bi.id_rs_data = s_rsd; bs.id_rs_data = s_rsd;
        bi.id_rt_data = s_rtd; bs.id_rt_data = s_rtd;
        bi.id_imm = s_imm;   bs.id_imm = s_imm;
        bi.id_rs = s_rs;     bs.id_rs = s_rs;
        bi.id_rt = s_rt;     bs.id_rt = s_rt;
        bi.id_rd = s_rd;     bs.id_rd = s_rd;
        bi.flush = s_flush;  bs.flush = s_flush;
        bi.hold = s_hold;    bs.hold = s_hold;
    endtask

    task automatic model_reset();
        m_ctrl = '0; m_ext = '0;
        m_pc4 = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0;
        m_cnt = 0; m_cnts = 0;
    endtask

    // Is the ID instruction waiting on the load now in EX?
    function automatic bit model_hz();
        bit reads_rs, reads_rt, ex_is_load;
        reads_rs   = !s_j;
        reads_rt   = s_ctrl[3] || s_ctrl[4] || s_ctrl[6] || s_ext[3];
        ex_is_load = m_ctrl[5];
        if (s_flush || !ex_is_load || m_rt == 0) return 1'b0;
        return (reads_rs && m_rt == s_rs) || (reads_rt && m_rt == s_rt);
    endfunction

    task automatic model_edge(bit hz);
        if (s_hold) return;
        m_ctrl = (s_flush || hz) ? 9'd0 : s_ctrl;
        m_ext  = (s_flush || hz) ? 4'd0 : s_ext;
        m_pc4 = s_pc4; m_rsd = s_rsd; m_rtd = s_rtd; m_imm = s_imm;
        m_rs = s_rs; m_rt = s_rt; m_rd = s_rd;
        if (hz) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnts < 3) m_cnts++;
        end
    endtask

    task automatic check_regs(string tag);
        chk({tag, ".ctrl"}, bi.ex_ctrl, m_ctrl);
        chk({tag, ".ext"}, bi.ex_ext, m_ext);
        chk({tag, ".data"}, {bi.ex_pc4, bi.ex_rs_data, bi.ex_rt_data,
                             bi.ex_imm}, {m_pc4, m_rsd, m_rtd, m_imm});
        chk({tag, ".spec"}, {bi.ex_rs, bi.ex_rt, bi.ex_rd},
            {m_rs, m_rt, m_rd});
        chk({tag, ".cnt"}, bi.stall_count, m_cnt[15:0]);
        chk({tag, ".cnt_s"}, bs.stall_count, m_cnts[1:0]);
        chk({tag, ".ctrl_s"}, bs.ex_ctrl, m_ctrl);
    endtask

    task automatic cyc(string tag);
        bit hz;
        @(negedge clk);
        apply();
        #1;
        hz = model_hz();
        chk({tag, ".pc_write"}, bi.pc_write, !(s_hold || hz));
        chk({tag, ".ifid_write"}, bi.ifid_write, !(s_hold || hz));
        chk({tag, ".pc_write_s"}, bs.pc_write, !(s_hold || hz));
        @(posedge clk);
        model_edge(hz);
        #1;
        check_regs(tag);
    endtask

    task automatic set_instr(logic [8:0] c, logic j, logic [4:0] rs,
                             logic [4:0] rt);
        s_ctrl = c; s_ext = '0; s_j = j;
        s_rs = rs; s_rt = rt; s_rd = 5'($urandom);
        s_pc4 = $urandom; s_rsd = $urandom; s_rtd = $urandom;
        s_imm = $urandom;
        s_flush = 1'b0; s_hold = 1'b0;
    endtask

    initial begin
        logic [8:0] hold_ctrl;
        model_reset();
        set_instr(9'd0, 1'b0, 5'd0, 5'd0);
        apply();
        #12;
        check_regs("reset");
        chk("reset.pc_write", bi.pc_write, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // load-use on rs: one bubble, then the R-type is captured
        set_instr(LW, 1'b0, 5'd1, 5'd5);
        cyc("lw1");
        set_instr(RTYP, 1'b0, 5'd5, 5'd7);
        cyc("luse");
        chk("luse.bubble", bi.ex_ctrl, 9'd0);
        chk("luse.count", bi.stall_count, 16'd1);
        cyc("luse_retry");
        chk("luse.capt", bi.ex_ctrl, RTYP);

        // load into r0 never stalls
        set_instr(LW, 1'b0, 5'd2, 5'd0);
        cyc("lw_r0");
        set_instr(RTYP, 1'b0, 5'd0, 5'd0);
        cyc("r0_nohz");
        chk("r0.capt", bi.ex_ctrl, RTYP);

        // jump does not read rs
        set_instr(LW, 1'b0, 5'd2, 5'd5);
        cyc("lw2");
        set_instr(9'd0, 1'b1, 5'd5, 5'd3);
        s_ext = 4'b0001;
        cyc("jump_nohz");
        chk("jump.ext", bi.ex_ext, 4'b0001);

        // flush overrides hazard
        set_instr(LW, 1'b0, 5'd2, 5'd6);
        cyc("lw3");
        set_instr(RTYP, 1'b0, 5'd6, 5'd6);
        s_flush = 1'b1;
        cyc("flush");
        chk("flush.ctrl", bi.ex_ctrl, 9'd0);
        chk("flush.count", bi.stall_count, 16'd1);

        // hold freezes everything for 3 cycles
        set_instr(LW, 1'b0, 5'd2, 5'd9);
        cyc("lw4");
        hold_ctrl = bi.ex_ctrl;
        for (int i = 0; i < 3; i++) begin
            set_instr(9'($urandom), 1'($urandom), 5'd9, 5'd9);
            s_hold = 1'b1;
            cyc("hold");
        end
        chk("hold.ctrl", bi.ex_ctrl, hold_ctrl);
        set_instr(9'd0, 1'b1, 5'd0, 5'd0);
        cyc("hold_release");

        // saturation on the 2-bit copy: three more hazards
        for (int i = 0; i < 3; i++) begin
            set_instr(LW, 1'b0, 5'd2, 5'd10);
            cyc("sat_lw");
            set_instr(9'b00_100_0000, 1'b0, 5'd11, 5'd10);
            cyc("sat_hz");
            cyc("sat_retry");
        end
        chk("sat.cnt16", bi.stall_count, 16'd4);
        chk("sat.cnt2", bs.stall_count, 2'd3);

        // asynchronous reset in the middle of a stall
        set_instr(LW, 1'b0, 5'd2, 5'd12);
        cyc("rst_lw");
        set_instr(RTYP, 1'b0, 5'd12, 5'd1);
        @(negedge clk);
        apply();
        #1;
        chk("rst.pre_stall", bi.pc_write, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst.ctrl", bi.ex_ctrl, 9'd0);
        chk("rst.cnt", bi.stall_count, 16'd0);
        chk("rst.pc_write", bi.pc_write, 1'b1);
        chk("rst.ifid_write", bi.ifid_write, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        model_edge(model_hz());
        #1;
        check_regs("rst_after");

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_instr(9'($urandom), 1'($urandom_range(0, 3) == 0),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) s_ctrl[5] = 1'b1;
            s_ext   = 4'($urandom);
            s_flush = ($urandom_range(0, 9) == 0);
            s_hold  = ($urandom_range(0, 9) == 0);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. It sits directly downstream of the decode control unit.
- Latches the 9-bit control bundle, extra opcode flags, register operands, immediate and register specifiers for the EX stage.
- Contains load-use hazard detection: inserts a bubble and stalls PC and IF/ID.
- Supports flush on a taken branch or jump, and a global hold from downstream memory.

Parameters:
- DATA_W, 32, datapath width.
- REG_W, 5, register specifier width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_in  in  9  decode control bundle.
  - [8:7] WB = {memtoreg, regwrite}.
  - [6:4] M = {branch, memread, memwrite}.
  - [3:0] EXE = {regdst, alusrc, r_type, beq}.
- ext_in  in  4  {bne, andi, ori, addi} from decode.
- j_in  in  1  jump decoded in ID (rs not read).
- id_pc4  in  DATA_W  PC+4 of the ID instruction.
- id_rs_data, id_rt_data  in  DATA_W  register file read data.
- id_imm  in  DATA_W  sign/zero-extended immediate.
- id_rs, id_rt, id_rd  in  REG_W  register specifiers.
- flush  in  1  squash the ID instruction (taken branch or jump).
- hold  in  1  freeze the whole stage (downstream not ready).
- ex_ctrl  out  9  registered control bundle.
- ex_ext  out  4  registered ext flags.
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered data.
- ex_rs, ex_rt, ex_rd  out  REG_W  registered specifiers.
- pc_write  out  1  PC enable (combinational).
- ifid_write  out  1  IF/ID enable (combinational).
- stall_count  out  CNT_W  number of load-use bubbles inserted, saturating.

Behaviour:
- Reset (async, any time, including mid-stall):
  - All ex_* outputs go to 0, so the reset state is a bubble.
  - stall_count goes to 0.
  - pc_write = ifid_write = 1 while rst is high.
- Hazard detection (combinational, from current register contents and ID inputs):
  - uses_rs = ~j_in.
  - uses_rt = ctrl_in[3] | ctrl_in[4] | ctrl_in[6] | ext_in[3], i.e. regdst | memwrite | branch | bne.
  - load_use = ex_ctrl[5] & (ex_rt != 0) & ((uses_rs & ex_rt == id_rs) | (uses_rt & ex_rt == id_rt)).
  - ex_ctrl[5] is the registered memread bit.
  - A hazard is reported only when flush is low.
- Register update on each rising clk, in priority order:
  1. hold = 1: all registers keep their value; stall_count unchanged.
  2. flush = 1: ex_ctrl and ex_ext load 0; data and specifier fields load their inputs (don't-care); stall_count unchanged.
  3. Hazard: ex_ctrl and ex_ext load 0 (bubble); data fields load their inputs; stall_count increments, saturating at all-ones.
  4. Otherwise: every field captures its input.
- Latency: one cycle from ID inputs to ex_* outputs.
- Stall outputs:
  - pc_write = ifid_write = ~(hold | hazard).
  - When flush is high, both stay 1; flush overrides hazard.
- A hazard lasts exactly one cycle: the next cycle the bubble is in EX, memread is 0, and the stalled instruction re-presents and is captured.
- Back-to-back loads with dependent use stall once per load-use pair.
- Simultaneous hold and flush: hold wins; flush must be held by its source until hold drops.
- Specifier r0: never causes a hazard.
- stall_count wraps: never; it saturates.

Decomposition:
- Shared package mips_pkg:
  - CTRL_W = 9.
  - Bit-index constants: WB_MEMTOREG=8, WB_REGWRITE=7, M_BRANCH=6, M_MEMREAD=5, M_MEMWRITE=4, EX_REGDST=3, EX_ALUSRC=2, EX_RTYPE=1, EX_BEQ=0.
  - EXT_BNE=3, EXT_ANDI=2, EXT_ORI=1, EXT_ADDI=0.
- Sub-module hazard_detect: purely combinational; produces load_use from ex_memread, ex_rt, id_rs, id_rt, uses_rs and uses_rt. Instantiated once.
- The register bank stays in id_ex_stage.

Test Plan:
- Reset mid-operation:
  - Stimulus: load an lw bundle (ctrl_in=9'b11_010_0100), then assert rst asynchronously between clock edges.
  - Response: ex_ctrl=0 and stall_count=0 immediately; pc_write=1.
- Load-use on rs:
  - Stimulus: ex holds lw with ex_rt=5; ID presents an R-type with id_rs=5 and id_rt=7.
  - Response: pc_write=ifid_write=0 for 1 cycle; next ex_ctrl=0; stall_count=1; the following cycle ex_ctrl=9'b01_000_1010.
- No hazard cases:
  - Stimulus 1: lw with ex_rt=0 and ID id_rs=0.
  - Stimulus 2: lw with ex_rt=5 and ID j_in=1, id_rs=5.
  - Response: no stall in either case; ID captured directly.
- Flush over hazard:
  - Stimulus: hazard condition plus flush=1.
  - Response: pc_write=1; ex_ctrl=0; stall_count unchanged.
- Hold freezes:
  - Stimulus: hold=1 for 3 cycles with changing inputs.
  - Response: ex_* constant; pc_write=0; stall_count constant.
- Saturation:
  - Stimulus: preload stall_count to 16'hFFFE, then trigger 3 hazards.
  - Response: count ends at 16'hFFFF.
